// File: rtl/lieat_wbu_pkg.sv
// Shared constants for the lieat writeback arbiter: source ordering, widths and
// the round-robin pointer step.
package lieat_wbu_pkg;

    localparam int WB_NSRC    = 5;
    localparam int WB_XLEN    = 32;
    localparam int WB_REG_IDX = 5;
    localparam int WB_PTR_W   = 3;

    // Fixed source order; the bit position of each unit in every per-source vector.
    typedef enum logic [WB_PTR_W-1:0] {
        WB_COM    = 3'd0,
        WB_LSU    = 3'd1,
        WB_MULDIV = 3'd2,
        WB_VPU    = 3'd3,
        WB_FPU    = 3'd4
    } wb_src_e;

    function automatic logic [WB_PTR_W-1:0] next_ptr(input logic [WB_PTR_W-1:0] p);
        return (p == WB_FPU) ? WB_COM : p + 1'b1;
    endfunction

endpackage

// File: rtl/lieat_wbu_rr_arb.sv
// Combinational round-robin arbiter: grants the first request at or after
// rr_ptr, wrapping modulo NSRC.
module lieat_wbu_rr_arb
    import lieat_wbu_pkg::*;
#(
    parameter int NSRC = WB_NSRC
) (
    input  logic [NSRC-1:0]     req,
    input  logic [WB_PTR_W-1:0] rr_ptr,
    output logic [NSRC-1:0]     grant
);

    logic [WB_PTR_W:0] idx;
    logic              found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NSRC; k++) begin
            idx = {1'b0, rr_ptr} + (WB_PTR_W + 1)'(k);
            if (idx >= (WB_PTR_W + 1)'(NSRC)) begin
                idx = idx - (WB_PTR_W + 1)'(NSRC);
            end
            if (!found && req[idx[WB_PTR_W-1:0]]) begin
                grant[idx[WB_PTR_W-1:0]] = 1'b1;
                found                    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lieat_wbu_arbiter.sv
// Writeback arbiter: one result buffer per execution unit, one round-robin
// writeback per cycle. Define LIEAT_WBU_BYPASS_EN for 0-cycle bypass of empty buffers.
module lieat_wbu_arbiter
    import lieat_wbu_pkg::*;
#(
    parameter int XLEN    = WB_XLEN,
    parameter int REG_IDX = WB_REG_IDX,
    parameter int NSRC    = WB_NSRC
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NSRC-1:0]         src_vld,
    output logic [NSRC-1:0]         src_rdy,
    input  logic [NSRC-1:0]         src_rdwen,
    input  logic [NSRC*REG_IDX-1:0] src_rd,
    input  logic [NSRC*XLEN-1:0]    src_data,
    input  logic [NSRC-1:0]         src_flush,
    output logic                    wbck_ena,
    output logic [NSRC-1:0]         wbck_op,
    output logic                    rf_wen,
    output logic [REG_IDX-1:0]      rf_waddr,
    output logic [XLEN-1:0]         rf_wdata
);

    logic [NSRC-1:0]     buf_vld;
    logic [NSRC-1:0]     buf_rdwen;
    logic [REG_IDX-1:0]  buf_rd   [NSRC];
    logic [XLEN-1:0]     buf_data [NSRC];
    logic [WB_PTR_W-1:0] rr_ptr;
    logic [WB_PTR_W-1:0] grant_idx;

    logic [NSRC-1:0] bypass;
    logic [NSRC-1:0] req;
    logic [NSRC-1:0] grant;
    logic [NSRC-1:0] load;

`ifdef LIEAT_WBU_BYPASS_EN
    // Only an empty buffer lets its source bid directly, so a buffered entry always wins.
    assign bypass = ~buf_vld & src_vld;
`else
    assign bypass = '0;
`endif

    assign req = (buf_vld | bypass) & ~src_flush & {NSRC{~reset}};

    lieat_wbu_rr_arb #(.NSRC(NSRC)) u_rr_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (grant)
    );

    assign src_rdy = reset ? '1 : (~src_flush & (~buf_vld | grant));
    assign load    = src_vld & src_rdy & ~(grant & bypass);

    always_comb begin
        wbck_ena  = |grant;
        wbck_op   = grant;
        rf_wen    = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        grant_idx = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                grant_idx = WB_PTR_W'(i);
                if (buf_vld[i]) begin
                    rf_wen   = buf_rdwen[i];
                    rf_waddr = buf_rd[i];
                    rf_wdata = buf_data[i];
                end else begin
                    rf_wen   = src_rdwen[i];
                    rf_waddr = src_rd[i*REG_IDX +: REG_IDX];
                    rf_wdata = src_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= next_ptr(grant_idx);
        end
    end

    // Flush beats load beats grant; load-and-grant together gives back-to-back writebacks.
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_vld <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (src_flush[i]) begin
                    buf_vld[i] <= 1'b0;
                end else if (load[i]) begin
                    buf_vld[i] <= 1'b1;
                end else if (grant[i]) begin
                    buf_vld[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NSRC; i++) begin
            if (load[i]) begin
                buf_rdwen[i] <= src_rdwen[i];
                buf_rd[i]    <= src_rd[i*REG_IDX +: REG_IDX];
                buf_data[i]  <= src_data[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: doc/lieat_wbu_arbiter.md
Name: lieat_wbu_arbiter

Overview:
- Writeback stage between the execution units (com, lsu, muldiv, vpu, fpu) and the integer register file.
- Buffers one completed result per unit and grants one writeback per cycle using round-robin priority.
- Drives the regfile write port and the retire strobe `wbck_ena`/`wbck_op` consumed by the OITF dependency tracker.
- Every accepted, unflushed result produces exactly one `wbck_ena` pulse, so OITF read pointers stay aligned.

Parameters:
- XLEN, 32, result data width.
- REG_IDX, 5, register index width (same value as the `REG_IDX` define).
- NSRC, 5, number of sources; fixed order com=0, lsu=1, muldiv=2, vpu=3, fpu=4.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- src_vld  in  NSRC  per-source result valid.
- src_rdy  out  NSRC  per-source accept.
- src_rdwen  in  NSRC  per-source rd write enable.
- src_rd  in  NSRC*REG_IDX  packed rd indices, source i at bits [i*REG_IDX +: REG_IDX].
- src_data  in  NSRC*XLEN  packed results.
- src_flush  in  NSRC  per-source flush: {fpu,vpu,muldiv,lsu,com}_flush.
- wbck_ena  out  1  one writeback this cycle.
- wbck_op  out  5  one-hot source of the writeback.
- rf_wen  out  1  regfile write enable.
- rf_waddr  out  REG_IDX  regfile write index.
- rf_wdata  out  XLEN  regfile write data.

Behaviour:
- Per-source state: buffer `buf_vld[i]`, `buf_rdwen[i]`, `buf_rd[i]`, `buf_data[i]`, plus round-robin pointer `rr_ptr` (3 bits, range 0..4).
- Reset: all `buf_vld`=0, `rr_ptr`=0. During and after reset, `wbck_ena`=0, `wbck_op`=0, `rf_wen`=0, `src_rdy`=all ones.
- Handshake:
  - `src_rdy[i] = ~src_flush[i] & (~buf_vld[i] | grant[i])`.
  - Transfer occurs when `src_vld[i] & src_rdy[i]`; the buffer loads on the next edge.
  - `src_vld` held without `src_rdy` must keep its payload stable.
- Arbitration:
  - Requests `req[i] = buf_vld[i] & ~src_flush[i]`.
  - Grant the first set request scanning `rr_ptr`, `rr_ptr+1`, … with wrap modulo 5 (4 wraps to 0).
  - At most one grant per cycle.
- Outputs:
  - `wbck_ena` = |grant.
  - `wbck_op` = grant.
  - `rf_wen` = `wbck_ena & buf_rdwen[g]`; `rf_waddr` = `buf_rd[g]`; `rf_wdata` = `buf_data[g]`.
  - When `wbck_ena`=0, `rf_waddr` and `rf_wdata` are 0.
  - `wbck_ena` fires even when rdwen=0, so the OITF entry still retires.
- Pointer update: on a grant, `rr_ptr` <= (g==4) ? 0 : g+1. With no grant, it holds.
- Buffer update per source, highest precedence first:
  1. `src_flush[i]`: `buf_vld[i]` <= 0, and incoming data is not accepted.
  2. Load: `buf_vld[i]` <= 1 with the new payload.
  3. Grant: `buf_vld[i]` <= 0.
- Simultaneous grant and load on the same source gives back-to-back writebacks, one per cycle, with no bubble.
- Latency: a result accepted in cycle N writes back in N+1 at the earliest.
- Order within a source is preserved, since each source has a single buffer.
- Full condition: a buffer that is valid and not granted deasserts `src_rdy`.
- Starvation bound: any valid request is granted within 5 cycles.
- Register index 0: x0 writes pass through unchanged; the regfile ignores them.

Optional Feature:
- Macro: LIEAT_WBU_BYPASS_EN.
- Defined:
  - A source whose buffer is empty and whose `src_vld` is high requests directly; its request is `src_vld[i] & ~src_flush[i]`.
  - If granted, the incoming payload is written back in the same cycle (0-cycle latency) and is not loaded into the buffer.
  - `src_rdy` for that source is high that cycle.
  - A buffered entry always has priority over its own source's bypass.
- Undefined: latency is exactly 1 cycle minimum, as described in Behaviour.

Decomposition:
- Shared package/defines: source index constants (`WB_COM`=0 … `WB_FPU`=4), NSRC, XLEN, `REG_IDX`.
- Sub-module `lieat_wbu_rr_arb`: NSRC-wide round-robin arbiter.
  - Inputs: req, rr_ptr.
  - Output: one-hot grant.
  - Purely combinational; `rr_ptr` lives in the parent.

Test Plan:
- Reset, then lsu returns rd=5, data=0xDEAD_BEEF at cycle 1 → cycle 2: `wbck_ena`=1, `wbck_op`=5'b00010, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF; `rr_ptr` becomes 2.
- All five sources valid in the same cycle with `rr_ptr`=0 → grants over the next 5 cycles are com, lsu, muldiv, vpu, fpu. `src_rdy` is low for the ungranted, full sources until they are granted.
- com holds valid for 4 consecutive results (rd 1,2,3,4) with no competition → 4 consecutive `wbck_ena` pulses, rd 1..4 in order, no bubble.
- muldiv buffered with rdwen=0 → `wbck_ena`=1, `wbck_op`=5'b00100, `rf_wen`=0.
- vpu buffered, then `src_flush[3]`=1 in the same cycle as its request → no grant that cycle; `buf_vld[3]` is 0 afterwards; no vpu writeback is ever issued.
- Reset asserted while fpu is buffered and lsu is transferring → next cycle all `buf_vld`=0, `wbck_ena`=0, `rr_ptr`=0.
- With LIEAT_WBU_BYPASS_EN defined, com valid, buffer empty, no other requests → `wbck_ena` in the same cycle, and com's buffer stays empty.
